// File: rtl/ifq_pkg.sv
// Shared types and constants for the instruction-fetch queue.
package ifq_pkg;

    localparam int IFQ_AW = 32;
    localparam int IFQ_DW = 32;

    typedef logic [IFQ_DW-1:0] word_t;
    typedef logic [IFQ_AW-1:0] addr_t;

    // One queued instruction together with the word address it came from
    typedef struct packed {
        word_t inst;
        addr_t pc;
    } fetch_entry_t;

    localparam addr_t PC_INCR  = addr_t'(1);
    localparam addr_t RESET_PC = '0;

endpackage

// File: rtl/ifetch_queue_if.sv
// Fetch-side bus: redirect input, memory request/response and decode hand-off.
// master = fetch queue, slave = surrounding pipeline / memory.
interface ifetch_queue_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          redirect_valid;
    logic [AW-1:0] redirect_pc;
    logic          mem_req_valid;
    logic          mem_req_ready;
    logic [AW-1:0] mem_req_addr;
    logic          mem_resp_valid;
    logic [DW-1:0] mem_resp_data;
    logic          inst_valid;
    logic          inst_ready;
    logic [DW-1:0] inst;
    logic [AW-1:0] inst_pc;

    modport master (
        input  redirect_valid, redirect_pc, mem_req_ready,
               mem_resp_valid, mem_resp_data, inst_ready,
        output mem_req_valid, mem_req_addr, inst_valid, inst, inst_pc
    );

    modport slave (
        output redirect_valid, redirect_pc, mem_req_ready,
               mem_resp_valid, mem_resp_data, inst_ready,
        input  mem_req_valid, mem_req_addr, inst_valid, inst, inst_pc
    );
endinterface

// File: rtl/ifq_fifo.sv
// Small synchronous FIFO of packed fetch entries; flush beats push and pop.
module ifq_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 64
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush_i,
    input  logic                       push_i,
    input  logic [W-1:0]               din_i,
    input  logic                       pop_i,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     occ_o,
    output logic [W-1:0]               dout_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Pointer and count update; pointers wrap naturally since DEPTH is a power of 2
    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (flush_i) begin
            wr_d  = '0;
            rd_d  = '0;
            cnt_d = '0;
        end else begin
            if (push_i) wr_d = wr_q + PW'(1);
            if (pop_i)  rd_d = rd_q + PW'(1);
            cnt_d = cnt_q + CW'(push_i) - CW'(pop_i);
        end
    end

    // Control state register
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    // Entry storage; contents are don't-care until counted valid, so no reset
    always_ff @(posedge clk) begin
        if (push_i && !flush_i) mem[wr_q] <= din_i;
    end

    assign full_o  = (cnt_q == CW'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign occ_o   = cnt_q;
    assign dout_o  = mem[rd_q];

endmodule

// File: rtl/ifetch_queue.sv
// Instruction-fetch queue: issues sequential word fetches under a credit limit,
// queues in-order responses with their PC, and flushes/refetches on redirect.
// Optional build macro IFQ_BYPASS_EN: a response arriving at an empty queue is
// presented to decode combinationally in the same cycle.
module ifetch_queue
    import ifq_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = IFQ_AW,
    parameter int DW    = IFQ_DW
) (
    input  logic          clk,
    input  logic          reset,
    ifetch_queue_if.master bus
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [AW-1:0] fetch_pc_q, fetch_pc_d;
    logic [AW-1:0] resp_pc_q, resp_pc_d;
    logic [CW-1:0] outst_q, outst_d;
    logic [CW-1:0] drop_q, drop_d;

    logic [CW-1:0]    occ;
    logic             fifo_full, fifo_empty;
    logic [DW+AW-1:0] fifo_dout;

    logic [CW:0] inflight;
    logic        req_valid, accept, resp, drop, keep, byp, byp_take, push, pop;

    // Credit: every accepted request already owns a queue slot for its response
    assign inflight  = {1'b0, outst_q} + {1'b0, occ};
    assign req_valid = !reset && !bus.redirect_valid && (inflight < (CW+1)'(DEPTH));
    assign accept    = req_valid && bus.mem_req_ready;

    // Response classification: drop stale data, bypass or enqueue the rest
    always_comb begin
        resp = bus.mem_resp_valid;
        drop = resp && (drop_q != '0);
        keep = resp && !drop && !bus.redirect_valid && !reset;
`ifdef IFQ_BYPASS_EN
        byp      = keep && fifo_empty;
        byp_take = byp && bus.inst_ready;
`else
        byp      = 1'b0;
        byp_take = 1'b0;
`endif
        push = keep && !byp_take && !fifo_full;
        pop  = !fifo_empty && bus.inst_ready;
    end

    // Next-state for PCs and counters; redirect overrides everything else
    always_comb begin
        outst_d    = outst_q + CW'(accept) - CW'(resp);
        drop_d     = drop_q - CW'(drop);
        fetch_pc_d = accept ? fetch_pc_q + AW'(PC_INCR) : fetch_pc_q;
        resp_pc_d  = keep   ? resp_pc_q  + AW'(PC_INCR) : resp_pc_q;
        if (bus.redirect_valid) begin
            // Every request still in flight after this cycle belongs to the old
            // path. drop_q only ever counts a subset of outst_q, so the new drop
            // count is simply what remains outstanding.
            drop_d     = outst_q - CW'(resp);
            fetch_pc_d = bus.redirect_pc;
            resp_pc_d  = bus.redirect_pc;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_q <= AW'(RESET_PC);
            resp_pc_q  <= AW'(RESET_PC);
            outst_q    <= '0;
            drop_q     <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            outst_q    <= outst_d;
            drop_q     <= drop_d;
        end
    end

    ifq_fifo #(.DEPTH(DEPTH), .W(DW + AW)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .flush_i (bus.redirect_valid),
        .push_i  (push),
        .din_i   ({bus.mem_resp_data, resp_pc_q}),
        .pop_i   (pop),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .occ_o   (occ),
        .dout_o  (fifo_dout)
    );

    assign bus.mem_req_valid = req_valid;
    assign bus.mem_req_addr  = fetch_pc_q;

    // Decode-side outputs: queue head, else bypassed response, else zero
    always_comb begin
        bus.inst_valid = 1'b0;
        bus.inst       = '0;
        bus.inst_pc    = '0;
        if (!fifo_empty) begin
            bus.inst_valid = 1'b1;
            bus.inst       = fifo_dout[DW+AW-1:AW];
            bus.inst_pc    = fifo_dout[AW-1:0];
        end else if (byp) begin
            bus.inst_valid = 1'b1;
            bus.inst       = bus.mem_resp_data;
            bus.inst_pc    = resp_pc_q;
        end
    end

endmodule

// File: tb/tb_ifetch_queue.sv
// Bench for ifetch_queue: 2-cycle fixed-latency memory model, scoreboard of
// expected (pc, data) pairs, directed phases for stalls, redirects and reset.
module tb_ifetch_queue;
    import ifq_pkg::*;

    localparam int DEPTH = 4;
    localparam int AW    = 32;
    localparam int DW    = 32;
`ifdef IFQ_BYPASS_EN
    localparam int FIRST_VLD = 2;
`else
    localparam int FIRST_VLD = 3;
`endif

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    ifetch_queue_if #(.AW(AW), .DW(DW)) bus ();

    ifetch_queue #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    logic [AW-1:0] exp_q[$];
    logic [AW-1:0] model_pc = '0;
    int            acc_cnt  = 0;
    int            pop_cnt  = 0;
    logic [AW-1:0] last_acc_addr = '0;
    logic [AW-1:0] last_pop_pc   = '0;

    function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Memory model: records accepts (and what the bench expects to see
    // delivered), returns data two cycles after accept
    logic          s_v, p1_v, p2_v;
    logic [AW-1:0] s_a, p1_a, p2_a;
    initial begin
        s_v = 0; p1_v = 0; p2_v = 0;
        s_a = '0; p1_a = '0; p2_a = '0;
        bus.mem_resp_valid = 1'b0;
        bus.mem_resp_data  = '0;
        forever begin
            @(negedge clk);
            s_v = bus.mem_req_valid && bus.mem_req_ready && !reset;
            s_a = bus.mem_req_addr;
            if (s_v) begin
                check("req_addr", s_a, model_pc);
                exp_q.push_back(model_pc);
                model_pc      = model_pc + 1;
                acc_cnt       = acc_cnt + 1;
                last_acc_addr = s_a;
            end
            @(posedge clk);
            #2;
            if (reset) begin
                p1_v = 0; p2_v = 0;
                bus.mem_resp_valid = 1'b0;
                bus.mem_resp_data  = '0;
            end else begin
                p2_v = p1_v; p2_a = p1_a;
                p1_v = s_v;  p1_a = s_a;
                bus.mem_resp_valid = p2_v;
                bus.mem_resp_data  = p2_v ? mem_word(p2_a) : '0;
            end
        end
    end

    // Monitor: every instruction consumed by decode is checked against the scoreboard
    initial begin
        logic [AW-1:0] e;
        forever begin
            @(negedge clk);
            if (!reset && bus.inst_valid && bus.inst_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_inst: got pc %0h, none expected", bus.inst_pc);
                end else begin
                    e = exp_q.pop_front();
                    check("inst_pc", bus.inst_pc, e);
                    check("inst_data", bus.inst, mem_word(e));
                end
                pop_cnt     = pop_cnt + 1;
                last_pop_pc = bus.inst_pc;
            end
        end
    end

    task automatic apply_reset(input bit chk);
        reset = 1'b1;
        bus.redirect_valid = 1'b0;
        exp_q.delete();
        model_pc = '0;
        tick(1);
        if (chk) begin
            @(negedge clk);
            check("rst_req_valid", bus.mem_req_valid, 0);
            check("rst_inst_valid", bus.inst_valid, 0);
            check("rst_inst", bus.inst, 0);
            check("rst_inst_pc", bus.inst_pc, 0);
            @(posedge clk);
            #1;
        end else begin
            tick(1);
        end
        exp_q.delete();
        reset = 1'b0;
    endtask

    task automatic wait_pop(input int base, input string name);
        int n = 0;
        while (pop_cnt <= base && n < 30) begin
            tick(1);
            n++;
        end
        if (pop_cnt <= base) begin
            total++;
            bad++;
            $display("FAIL %s: no instruction within 30 cycles, got none expected one", name);
        end
    endtask

    task automatic wait_acc(input int base, input string name);
        int n = 0;
        while (acc_cnt <= base && n < 30) begin
            tick(1);
            n++;
        end
        if (acc_cnt <= base) begin
            total++;
            bad++;
            $display("FAIL %s: no request accepted within 30 cycles", name);
        end
    endtask

    initial begin
        int base;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.mem_req_ready  = 1'b1;
        bus.inst_ready     = 1'b1;
        #1;

        // Phase 1: streaming fetch, addresses 0,1,2... and first-delivery latency
        apply_reset(1);
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            check("p1_req_valid", bus.mem_req_valid, 1);
            check("p1_req_addr", bus.mem_req_addr, c);
            check("p1_inst_valid", bus.inst_valid, (c >= FIRST_VLD) ? 1 : 0);
            if (c == FIRST_VLD) check("p1_first_pc", bus.inst_pc, 0);
            @(posedge clk);
            #1;
        end

        // Phase 2: decode stalled, exactly DEPTH requests, then drain and refetch at 4
        bus.inst_ready = 1'b0;
        apply_reset(0);
        base = acc_cnt;
        tick(12);
        check("p2_acc_count", acc_cnt - base, 4);
        @(negedge clk);
        check("p2_req_valid_full", bus.mem_req_valid, 0);
        check("p2_head_pc", bus.inst_pc, 0);
        @(posedge clk);
        #1;
        base = acc_cnt;
        bus.inst_ready = 1'b1;
        wait_acc(base, "p2_refetch");
        check("p2_refetch_addr", last_acc_addr, 4);
        tick(6);

        // Phase 3: memory not ready, address held at 0
        bus.mem_req_ready = 1'b0;
        apply_reset(0);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("p3_hold_valid", bus.mem_req_valid, 1);
            check("p3_hold_addr", bus.mem_req_addr, 0);
            @(posedge clk);
            #1;
        end
        bus.mem_req_ready = 1'b1;
        @(negedge clk);
        check("p3_go_addr0", bus.mem_req_addr, 0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("p3_go_addr1", bus.mem_req_addr, 1);
        @(posedge clk);
        #1;
        tick(6);

        // Phase 4: redirect to 0x40 with requests in flight
        apply_reset(0);
        tick(3);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h40;
        model_pc           = 32'h40;
        @(negedge clk);
        check("p4_req_valid_redir", bus.mem_req_valid, 0);
        @(posedge clk);
        #1;
        bus.redirect_valid = 1'b0;
        exp_q.delete();
        base = pop_cnt;
        @(negedge clk);
        check("p4_queue_empty", bus.inst_valid, 0);
        check("p4_req_valid", bus.mem_req_valid, 1);
        check("p4_req_addr", bus.mem_req_addr, 32'h40);
        @(posedge clk);
        #1;
        wait_pop(base, "p4_first_inst");
        check("p4_first_pc", last_pop_pc, 32'h40);
        tick(4);

        // Phase 5: back-to-back redirects, the second one wins
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h10;
        model_pc           = 32'h10;
        tick(1);
        exp_q.delete();
        bus.redirect_pc    = 32'h20;
        model_pc           = 32'h20;
        tick(1);
        bus.redirect_valid = 1'b0;
        exp_q.delete();
        base = pop_cnt;
        @(negedge clk);
        check("p5_req_addr", bus.mem_req_addr, 32'h20);
        check("p5_queue_empty", bus.inst_valid, 0);
        @(posedge clk);
        #1;
        wait_pop(base, "p5_first_inst");
        check("p5_first_pc", last_pop_pc, 32'h20);
        tick(4);

        // Phase 6: reset in the middle of a stalled, busy queue
        bus.inst_ready = 1'b0;
        tick(4);
        apply_reset(1);
        @(negedge clk);
        check("p6_req_valid", bus.mem_req_valid, 1);
        check("p6_req_addr", bus.mem_req_addr, 0);
        check("p6_inst_valid", bus.inst_valid, 0);
        @(posedge clk);
        #1;
        bus.inst_ready = 1'b1;
        tick(6);

        // Stop fetching and let everything drain through the scoreboard
        bus.mem_req_ready = 1'b0;
        tick(10);
        check("drain_remaining", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
